// File: rtl/vram_arbiter.sv
// Single-port 160x120 RGB332 framebuffer shared by 4x-upscaled VGA scan-out and one req/ack writer.
// Pixel path: read at h=140+4k, shown at h=145+4k..148+4k; writes ack 1 cycle after grant, video slots win.
// Define VRAM_ARB_VBLANK_WR_EN to confine writes to vertical blanking (tear-free updates).
module vram_arbiter #(
  parameter int FB_W    = 160,
  parameter int FB_H    = 120,
  parameter int H_START = 144,
  parameter int V_START = 35
) (
  input  logic        VGA_CLK2,
  input  logic        reset,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  input  logic        wr_req,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic [7:0]  pixel_color,
  output logic        de
);

  localparam int FB_CELLS = FB_W * FB_H;

  logic [7:0]  mem [FB_CELLS];
  logic [7:0]  rd_data;
  logic [9:0]  v_off;
  logic [9:0]  h_off;
  logic [14:0] rd_addr;
  logic        active_line;
  logic        video_slot;
  logic        load_slot;
  logic        wr_window;
  logic        grant;
  logic        wr_en;

  assign active_line = (v_counter >= 10'(V_START)) && (v_counter < 10'(V_START + 480));
  assign v_off       = v_counter - 10'(V_START);
  assign h_off       = h_counter - 10'(H_START - 4);

  // Read slot leads the displayed cell by one 4-pixel group so the RAM latency is hidden.
  assign video_slot = active_line && (h_counter[1:0] == 2'b00) &&
                      (h_counter >= 10'(H_START - 4)) && (h_counter <= 10'(H_START + 636));
  assign load_slot  = active_line && (h_counter[1:0] == 2'b00) &&
                      (h_counter >= 10'(H_START)) && (h_counter <= 10'(H_START + 636));
  assign rd_addr    = 15'(v_off[9:2]) * 15'(FB_W) + 15'(h_off[9:2]);

`ifdef VRAM_ARB_VBLANK_WR_EN
  assign wr_window = !active_line;
`else
  assign wr_window = 1'b1;
`endif

  // Blocking grants while wr_ack is high stops a held request from being written twice.
  assign grant = wr_req && !video_slot && !wr_ack && wr_window;
  assign wr_en = grant && (wr_addr < 15'(FB_CELLS));

  // One access per cycle: grant and video_slot are mutually exclusive.
  always_ff @(posedge VGA_CLK2) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (video_slot) begin
      rd_data <= mem[rd_addr];
    end
  end

  always_ff @(posedge VGA_CLK2) begin
    if (reset) begin
      wr_ack      <= 1'b0;
      de          <= 1'b0;
      pixel_color <= 8'h00;
    end else begin
      wr_ack <= grant;
      if (!active_line || (h_counter[1:0] == 2'b00)) begin
        de          <= load_slot;
        pixel_color <= load_slot ? rd_data : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: drives timing counters directly, compares against a cell-level framebuffer model.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  h_counter = '0;
  logic [9:0]  v_counter = '0;
  logic        wr_req = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack;
  logic [7:0]  pixel_color;
  logic        de;

  vram_arbiter dut (
    .VGA_CLK2    (clk),
    .reset       (reset),
    .h_counter   (h_counter),
    .v_counter   (v_counter),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .pixel_color (pixel_color),
    .de          (de)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cur_h = 0;
  int         cur_v = 0;
  bit         exp_ack = 1'b0;
  bit         px_chk_en = 1'b1;
  bit         rand_wr = 1'b0;
  logic [7:0] ref_mem [19200];
  logic [7:0] line_px [160];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s h=%0d v=%0d: got 0x%0h expected 0x%0h", tag, cur_h, cur_v, got, exp);
    end
  endtask

  // One pixel clock at (cur_h, cur_v); checks the registered outputs right after the edge.
  task automatic step();
    bit         act;
    bit         slot;
    bit         grant;
    bit         exp_de;
    logic [7:0] exp_px;
    int         vis;
    h_counter = 10'(cur_h);
    v_counter = 10'(cur_v);
    act  = (cur_v >= 35) && (cur_v < 515);
    slot = act && (cur_h % 4 == 0) && (cur_h >= 140) && (cur_h <= 780);
    if (slot) line_px[(cur_h - 140) / 4] = ref_mem[((cur_v - 35) / 4) * 160 + (cur_h - 140) / 4];
    grant = wr_req && !slot && !exp_ack;
`ifdef VRAM_ARB_VBLANK_WR_EN
    if (act) grant = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (grant && (wr_addr < 15'd19200)) ref_mem[wr_addr] = wr_data;
    exp_ack = grant && !reset;
    chk("wr_ack", {31'd0, wr_ack}, {31'd0, exp_ack});
    if (px_chk_en) begin
      vis    = cur_h + 1;
      exp_de = 1'b0;
      exp_px = 8'h00;
      if (!reset && act && (vis >= 145) && (vis <= 784)) begin
        exp_de = 1'b1;
        exp_px = line_px[(vis - 145) / 4];
      end
      chk("de", {31'd0, de}, {31'd0, exp_de});
      chk("pixel_color", {24'd0, pixel_color}, {24'd0, exp_px});
    end
    cur_h++;
    if (cur_h == 800) begin
      cur_h = 0;
      cur_v = (cur_v == 524) ? 0 : cur_v + 1;
    end
  endtask

  task automatic cyc();
    step();
    if (wr_ack) wr_req = 1'b0;
    if (rand_wr && !wr_req && ($urandom_range(0, 2) == 0)) begin
      wr_req = 1'b1;
      if ($urandom_range(0, 7) == 0) wr_addr = 15'(19200 + $urandom_range(0, 13567));
      else                           wr_addr = 15'($urandom_range(0, 639));
      wr_data = 8'($urandom);
    end
  endtask

  task automatic run_to(input int h);
    do cyc(); while (cur_h != h);
  endtask

  task automatic goto_line(input int v);
    while (cur_h != 0) cyc();
    cur_v = v;
  endtask

  initial begin
    bit got;
    bit prev;
    int n;

    for (int i = 0; i < 19200; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 160; i++) line_px[i] = 8'h00;

    // Reset
    step();
    chk("reset_de", {31'd0, de}, 32'd0);
    chk("reset_px", {24'd0, pixel_color}, 32'd0);
    step();
    reset = 1'b0;

    // Preload rows 0..3 with (x+y) through the writer port during blanking
    for (int a = 0; a < 640; a++) begin
      wr_req  = 1'b1;
      wr_addr = 15'(a);
      wr_data = 8'((a % 160) + (a / 160));
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        step();
        got = wr_ack;
      end
      chk("preload_ack", {31'd0, got}, 32'd1);
    end
    wr_req = 1'b0;

    // First displayed pass, with a request landing on a video slot
    goto_line(35);
    repeat (2 * 800) cyc();
`ifndef VRAM_ARB_VBLANK_WR_EN
    run_to(140);
    wr_req  = 1'b1;
    wr_addr = 15'd485;
    wr_data = 8'h3C;
    step();
    chk("ack_h141", {31'd0, wr_ack}, 32'd0);
    step();
    chk("ack_h142", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
`endif
    goto_line(43);
    run_to(143);
    cyc();
    chk("de_h144", {31'd0, de}, 32'd0);
    run_to(184);
    cyc();
    chk("px_h185", {24'd0, pixel_color}, 32'h0C);
    chk("de_h185", {31'd0, de}, 32'd1);
    run_to(784);
    cyc();
    chk("de_h785", {31'd0, de}, 32'd0);
    goto_line(44);
    repeat (7 * 800) cyc();

    // Six back-to-back writes with wr_req held high
    goto_line(516);
    wr_req  = 1'b1;
    wr_addr = 15'(2 * 160 + 20);
    wr_data = 8'h60;
    n    = 0;
    prev = 1'b0;
    for (int i = 0; i < 40 && n < 6; i++) begin
      step();
      if (wr_ack) begin
        n++;
        chk("ack_gap", {31'd0, prev}, 32'd0);
        wr_addr = wr_addr + 15'd1;
        wr_data = wr_data + 8'd1;
        if (n == 6) wr_req = 1'b0;
      end
      prev = wr_ack;
    end
    chk("six_acks", n, 32'd6);
    step();
    chk("six_acks_done", {31'd0, wr_ack}, 32'd0);

    // Blanking write of 0xA5 to cell (1,1)
    goto_line(517);
    wr_req  = 1'b1;
    wr_addr = 15'd161;
    wr_data = 8'hA5;
    step();
    chk("a5_ack", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    step();
    chk("a5_ack_once", {31'd0, wr_ack}, 32'd0);

    // Out-of-range address is acked and ignored
    goto_line(518);
    wr_req  = 1'b1;
    wr_addr = 15'd19200;
    wr_data = 8'hFF;
    step();
    chk("oob_ack", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    step();

    // Second pass shows the new contents
    goto_line(35);
    repeat (4 * 800) cyc();
    run_to(148);
    cyc();
    chk("a5_px", {24'd0, pixel_color}, 32'hA5);
    chk("a5_de", {31'd0, de}, 32'd1);
    goto_line(40);
    repeat (11 * 800) cyc();

    // Random writer traffic against the model
    goto_line(35);
    rand_wr = 1'b1;
    repeat (16 * 800) cyc();
    rand_wr = 1'b0;
    goto_line(519);
    for (int i = 0; i < 8 && wr_req; i++) cyc();
    chk("rand_drain", {31'd0, wr_req}, 32'd0);
    wr_req = 1'b0;

    // Reset in the middle of an active line
    goto_line(40);
    run_to(301);
    reset   = 1'b1;
    wr_req  = 1'b1;
    wr_addr = 15'd400;
    wr_data = 8'h77;
    step();
    chk("rst_de", {31'd0, de}, 32'd0);
    chk("rst_px", {24'd0, pixel_color}, 32'd0);
    chk("rst_ack", {31'd0, wr_ack}, 32'd0);
    reset     = 1'b0;
    px_chk_en = 1'b0;
    goto_line(41);
    px_chk_en = 1'b1;
    repeat (6 * 800) cyc();

`ifdef VRAM_ARB_VBLANK_WR_EN
    // Writes stall for the whole active region
    goto_line(519);
    for (int i = 0; i < 8 && wr_req; i++) cyc();
    wr_req = 1'b0;
    goto_line(100);
    px_chk_en = 1'b0;
    wr_req  = 1'b1;
    wr_addr = 15'd5;
    wr_data = 8'h11;
    repeat (800) cyc();
    goto_line(514);
    repeat (800) cyc();
    got = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      got = got | wr_ack;
    end
    chk("vblank_ack", {31'd0, got}, 32'd1);
    px_chk_en = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
